// File: rtl/lcd_mem_arbiter.sv
// lcd_mem_arbiter
//   Shares one single-port synchronous image RAM between the LCD scan path
//   (deadline-critical reads, absolute priority) and a host writer whose
//   writes are buffered in a small FIFO and drained in otherwise idle slots.
//
// Ports
//   clk_i, rst_ni          clock (rising edge) and asynchronous active-low reset
//   disp_req_i/addr_i      one display read per cycle the request is high
//   disp_data_o/valid_o    read data, valid pulse exactly 3 cycles after request
//   wr_req_i/addr_i/data_i host write, held until wr_ack_o
//   wr_ack_o               write accepted into the FIFO this cycle (combinational)
//   wr_level_o             FIFO occupancy 0..FIFO_DEPTH
//   mem_addr_o/wdata_o/we_o registered RAM command
//   mem_q_i                RAM read data, one cycle after the command
module lcd_mem_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ack_o,
  output logic [LVL_W-1:0]  wr_level_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_q_i
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Write buffer storage and bookkeeping
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  // Memory command registers
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;

  // Read pipeline: pend1 = command on the RAM port, pend2 = RAM data valid
  logic              rd_pend1_q, rd_pend1_d;
  logic              rd_pend2_q, rd_pend2_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic grant_disp_s;
  logic grant_wr_s;

  assign full_s  = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty_s = (level_q == {LVL_W{1'b0}});

  // The ack is gated by reset so nothing is accepted while the block is held
  // in reset. A full FIFO refuses even when a pop happens the same cycle.
  assign wr_ack_o = wr_req_i & rst_ni & ~full_s;
  assign push_s   = wr_ack_o;

  // Display always wins; a write only uses a slot the display leaves free.
  assign grant_disp_s = disp_req_i;
  assign grant_wr_s   = ~disp_req_i & ~empty_s;
  assign pop_s        = grant_wr_s;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_s) begin
      wptr_d = wptr_q + PTR_W'(1'b1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PTR_W'(1'b1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1'b1);
      2'b01:   level_d = level_q - LVL_W'(1'b1);
      default: level_d = level_q;
    endcase
  end

  // Slot arbitration: builds the next memory command and read-pipeline head
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rd_pend1_d  = 1'b0;
    if (grant_disp_s) begin
      mem_addr_d = disp_addr_i;
      mem_we_d   = 1'b0;
      rd_pend1_d = 1'b1;
    end else if (grant_wr_s) begin
      mem_addr_d  = fifo_addr_q[rptr_q];
      mem_wdata_d = fifo_data_q[rptr_q];
      mem_we_d    = 1'b1;
      rd_pend1_d  = 1'b0;
    end else begin
      // Idle slot: address and write data hold their last value.
      mem_we_d   = 1'b0;
      rd_pend1_d = 1'b0;
    end
  end

  // Read return path: capture RAM data in the cycle it is valid
  always_comb begin
    rd_pend2_d   = rd_pend1_q;
    disp_valid_d = rd_pend2_q;
    if (rd_pend2_q) begin
      disp_data_d = mem_q_i;
    end else begin
      disp_data_d = disp_data_q;
    end
  end

  // FIFO storage; a slot is written only on an accepted push
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= {ADDR_W{1'b0}};
        fifo_data_q[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      fifo_addr_q[wptr_q] <= wr_addr_i;
      fifo_data_q[wptr_q] <= wr_data_i;
    end
  end

  // FIFO pointers and level; reset discards any buffered writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= {PTR_W{1'b0}};
      rptr_q  <= {PTR_W{1'b0}};
      level_q <= {LVL_W{1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Registered memory command
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      mem_we_q    <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  // Read pipeline; reset drops reads in flight so they never return
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend1_q   <= 1'b0;
      rd_pend2_q   <= 1'b0;
      disp_data_q  <= {DATA_W{1'b0}};
      disp_valid_q <= 1'b0;
    end else begin
      rd_pend1_q   <= rd_pend1_d;
      rd_pend2_q   <= rd_pend2_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign wr_level_o   = level_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_we_o     = mem_we_q;
  assign disp_data_o  = disp_data_q;
  assign disp_valid_o = disp_valid_q;

endmodule

// File: tb/tb_lcd_mem_arbiter.sv
// tb_lcd_mem_arbiter
//   Drives directed and random traffic into lcd_mem_arbiter, emulates the
//   single-port RAM, and compares every output each cycle against a
//   transaction-level model (FIFO as a queue, reads as (due-cycle, data)).
module tb_lcd_mem_arbiter;
  localparam int AW    = 17;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack;
  logic [LW-1:0] wr_level;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_q = '0;

  always #5 clk = ~clk;

  lcd_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .disp_req_i(disp_req), .disp_addr_i(disp_addr),
    .disp_data_o(disp_data), .disp_valid_o(disp_valid),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_ack_o(wr_ack), .wr_level_o(wr_level),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
    .mem_q_i(mem_q)
  );

  // Single-port synchronous RAM
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_q <= mem[mem_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } went_t;
  typedef struct packed { int due; logic [DW-1:0] d; } rd_t;
  went_t         mq[$];     // host writes accepted, not yet issued
  rd_t           rq[$];     // reads in flight with the cycle their pulse is due
  int            cyc = 0;
  logic          e_we = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;
  logic          e_dv = 1'b0;
  logic [DW-1:0] e_dd = '0;

  task automatic model_step();
    went_t e;
    logic  full;
    logic  push;
    if (!rst_n) begin
      mq.delete();
      rq.delete();
      e_we = 1'b0; e_addr = '0; e_wdata = '0; e_dv = 1'b0; e_dd = '0;
    end else begin
      full = (mq.size() == DEPTH);
      push = wr_req && !full;
      if (e_we) ref_mem[e_addr] = e_wdata;   // write issued last cycle lands now
      if (disp_req) begin
        rq.push_back('{due: cyc + 3, d: ref_mem[disp_addr]});
        e_we = 1'b0;
        e_addr = disp_addr;
      end else if (mq.size() != 0) begin
        e = mq.pop_front();
        e_we = 1'b1; e_addr = e.a; e_wdata = e.d;
      end else begin
        e_we = 1'b0;
      end
      if (push) mq.push_back('{a: wr_addr, d: wr_data});
      cyc++;
      if (rq.size() != 0 && rq[0].due == cyc) begin
        e_dv = 1'b1; e_dd = rq[0].d; void'(rq.pop_front());
      end else begin
        e_dv = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Per-cycle compare plus a small activity log for the directed tests
  went_t wlog[$];
  int    vcnt = 0;
  initial forever begin
    @(negedge clk);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("disp_valid", disp_valid, e_dv);
    chk("disp_data", disp_data, e_dd);
    chk("wr_ack", wr_ack, wr_req & rst_n & (mq.size() != DEPTH));
    chk("wr_level", wr_level, mq.size());
    if (mem_we) wlog.push_back('{a: mem_addr, d: mem_wdata});
    if (disp_valid) vcnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic got;
    got = 1'b0;
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = wr_ack;
      tick();
    end
    wr_req = 1'b0;
    chk("push_ack", got, 1'b1);
  endtask

  initial begin
    logic got;
    logic done;
    int   k;
    int   c;
    logic busy;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'hC000 | 16'(i);
    end
    for (int i = 0; i < 8; i++) mem[i] = 16'h0100 + 16'(i);
    mem[17'h10] = 16'hF81F;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

    repeat (3) tick();
    @(negedge clk);
    chk("rst_level", wr_level, 0);
    chk("rst_valid", disp_valid, 0);
    chk("rst_we", mem_we, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single read of 0x10
    disp_req = 1'b1; disp_addr = 17'h00010;
    tick(); disp_req = 1'b0;
    @(negedge clk);
    chk("t1_addr", mem_addr, 32'h10);
    chk("t1_we", mem_we, 0);
    chk("t1_valid_t1", disp_valid, 0);
    tick(); @(negedge clk);
    chk("t1_valid_t2", disp_valid, 0);
    tick(); @(negedge clk);
    chk("t1_valid_t3", disp_valid, 1);
    chk("t1_data", disp_data, 32'hF81F);
    tick(); @(negedge clk);
    chk("t1_valid_t4", disp_valid, 0);

    // 2: eight back-to-back reads of 0..7
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin disp_req = 1'b1; disp_addr = AW'(i); end
      else disp_req = 1'b0;
      tick(); @(negedge clk);
      c = i + 1;
      if (c >= 3 && c <= 10) begin
        chk("t2_valid", disp_valid, 1);
        chk("t2_data", disp_data, 32'h100 + 32'(c - 3));
      end else begin
        chk("t2_valid_off", disp_valid, 0);
      end
    end

    // 3: five writes while the display hogs every slot, then drain
    tick();
    disp_req = 1'b1; disp_addr = 17'h40; k = 0; wlog.delete();
    for (int n = 0; n < 10; n++) begin
      wr_req = (k < 5); wr_addr = AW'(32'h20 + k); wr_data = DW'(32'hAAA0 + k);
      @(negedge clk);
      got = wr_req & wr_ack;
      tick();
      if (got) k++;
    end
    @(negedge clk);
    chk("t3_acks", k, 4);
    chk("t3_level", wr_level, 4);
    chk("t3_fifth_ack", wr_ack, 0);
    chk("t3_no_write", wlog.size(), 0);
    tick();
    disp_req = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 30 && !done; n++) begin
      wr_req = (k < 5); wr_addr = AW'(32'h20 + k); wr_data = DW'(32'hAAA0 + k);
      @(negedge clk);
      got = wr_req & wr_ack;
      if (k == 5 && wr_level == 0) done = 1'b1;
      tick();
      if (got) k++;
    end
    wr_req = 1'b0;
    chk("t3_drain_done", done, 1);
    repeat (3) tick();
    chk("t3_writes", wlog.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < wlog.size()) begin
        chk("t3_wr_addr", wlog[i].a, 32'h20 + 32'(i));
        chk("t3_wr_data", wlog[i].d, 32'hAAA0 + 32'(i));
      end
    end

    // 4: reads on odd cycles interleaved with three queued writes
    disp_req = 1'b1; disp_addr = 17'h41;
    for (int i = 0; i < 3; i++) push_write(AW'(32'h60 + i), DW'(32'hBBB0 + i));
    vcnt = 0; wlog.delete();
    for (int j = 0; j < 10; j++) begin
      disp_req = (j % 2 == 1); disp_addr = AW'(32'h44 + j);
      tick();
    end
    disp_req = 1'b0;
    repeat (6) tick();
    chk("t4_pulses", vcnt, 8);
    chk("t4_writes", wlog.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wlog.size()) chk("t4_wr_addr", wlog[i].a, 32'h60 + 32'(i));
    end

    // 5: write then read back the same address
    push_write(17'h30, 16'h1234);
    repeat (3) tick();
    disp_req = 1'b1; disp_addr = 17'h30;
    tick(); disp_req = 1'b0;
    tick(); tick(); @(negedge clk);
    chk("t5_valid", disp_valid, 1);
    chk("t5_data", disp_data, 32'h1234);
    tick(); tick(); @(negedge clk);
    chk("t5_valid_off", disp_valid, 0);
    chk("t5_data_hold", disp_data, 32'h1234);

    // 6: reset with queued writes and reads in flight
    tick();
    disp_req = 1'b1; disp_addr = 17'h42;
    for (int i = 0; i < 3; i++) push_write(AW'(32'h50 + i), DW'(32'hDDD0 + i));
    rst_n = 1'b0; disp_req = 1'b0; wr_req = 1'b1; wr_addr = 17'h55; wr_data = 16'h5555;
    @(negedge clk);
    chk("t6_ack_in_rst", wr_ack, 0);
    chk("t6_level_in_rst", wr_level, 0);
    tick(); tick();
    rst_n = 1'b1; wr_req = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("t6_valid", disp_valid, 0);
      chk("t6_we", mem_we, 0);
      chk("t6_level", wr_level, 0);
      tick();
    end
    for (int i = 0; i < 3; i++) chk("t6_mem", mem[32'h50 + i], 32'hC050 + 32'(i));

    // Random traffic with bursty display activity
    busy = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      got = wr_req & wr_ack;
      tick();
      if (got) wr_req = 1'b0;
      if (!wr_req && $urandom_range(0, 2) == 0) begin
        wr_req = 1'b1;
        wr_addr = AW'($urandom_range(0, 63));
        wr_data = DW'($urandom);
      end
      if ($urandom_range(0, 15) == 0) busy = ~busy;
      disp_req = busy ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
      disp_addr = AW'($urandom_range(0, 63));
    end
    disp_req = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      got = wr_req & wr_ack;
      if (!wr_req && wr_level == 0 && !mem_we) done = 1'b1;
      tick();
      if (got) wr_req = 1'b0;
    end
    chk("rand_drain", done, 1);
    repeat (3) tick();
    for (int a = 0; a < 256; a++) chk("mem_image", mem[a], ref_mem[a]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_mem_arbiter.md
Name: lcd_mem_arbiter

Overview:
- Shares one single-port synchronous image memory (16-bit pixel words) between two requesters:
  - the LCD scan path, which is deadline-critical and issues one read per active pixel;
  - a host writer that updates image contents.
- Display reads have absolute priority.
- Host writes are buffered in a small FIFO and drained in idle memory slots, e.g. during blanking or when DEN is low.
- Sits between the address generator/colour converter and the image RAM.

Parameters:
- ADDR_W, 17, memory address width.
- DATA_W, 16, pixel word width.
- FIFO_DEPTH, 4, write-buffer entries (power of 2, >= 2).
- LVL_W, 3, width of WR_LEVEL; must hold 0..FIFO_DEPTH.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST_n  in  1  asynchronous active-low reset.
- DISP_REQ  in  1  display read request, one cycle per pixel.
- DISP_ADDR  in  ADDR_W  pixel address, sampled when DISP_REQ=1.
- DISP_DATA  out  DATA_W  read data returned to display path.
- DISP_VALID  out  1  DISP_DATA valid this cycle.
- WR_REQ  in  1  host write request; hold with address/data until acked.
- WR_ADDR  in  ADDR_W  host write address.
- WR_DATA  in  DATA_W  host write data.
- WR_ACK  out  1  write accepted into FIFO this cycle.
- WR_LEVEL  out  LVL_W  FIFO occupancy 0..FIFO_DEPTH.
- MEM_ADDR  out  ADDR_W  memory address, registered.
- MEM_WDATA  out  DATA_W  memory write data, registered.
- MEM_WE  out  1  memory write enable, registered.
- MEM_Q  in  DATA_W  memory read data, one cycle after address/WE sampled.

Behaviour:
Reset (RST_n=0, asynchronous):
- FIFO emptied: WR_LEVEL=0.
- MEM_ADDR=0, MEM_WDATA=0, MEM_WE=0.
- DISP_DATA=0, DISP_VALID=0.
- All pipeline valid bits cleared.
- WR_ACK=0 while in reset.

Write handshake:
- WR_ACK = WR_REQ & (WR_LEVEL != FIFO_DEPTH), combinational.
- Push occurs on the edge where WR_REQ=1 and WR_ACK=1.
- When full, a push is refused even if a pop happens in the same cycle, i.e. no bypass.
- On a simultaneous push and pop when not full: level unchanged, ordering preserved.

Slot arbitration (per cycle t, decided combinationally, registered at edge end of t):
- GRANT_DISP: DISP_REQ=1.
  - MEM_ADDR<=DISP_ADDR, MEM_WE<=0, rd_pend1<=1.
- GRANT_WR: DISP_REQ=0 and FIFO not empty.
  - MEM_ADDR<=head.addr, MEM_WDATA<=head.data, MEM_WE<=1, pop head, rd_pend1<=0.
- IDLE: otherwise.
  - MEM_WE<=0, rd_pend1<=0; MEM_ADDR and MEM_WDATA hold their last value.

Read pipeline:
- Cycle t: request.
- t+1: MEM_ADDR is driven.
- t+2: MEM_Q is valid, and DISP_DATA<=MEM_Q at the end of t+2.
- t+3: DISP_VALID=1.
- Fixed latency 3; fully pipelined, one read per cycle sustained.
- DISP_VALID is a 1-cycle pulse per request.
- DISP_DATA holds its value between pulses.

Write timing:
- An entry pushed at edge e can be written to memory no earlier than the cycle after e.
- Writes are performed in FIFO order.
- Display reads may starve writes indefinitely; this is accepted because blanking guarantees slots.

Hazards:
- A display read of an address with a pending FIFO write returns the memory contents, not the FIFO data. No forwarding.
- A read one slot after a write to the same address returns the new data, since memory write completes at its edge.

Reset mid-operation:
- In-flight reads are dropped; no DISP_VALID after reset release for pre-reset requests.
- Buffered writes are discarded.

Widths:
- WR_LEVEL counts 0..FIFO_DEPTH.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.

Test Plan:
1. Reset, then DISP_REQ pulse with DISP_ADDR=0x00010 and memory model preloaded with 0x00010->0xF81F -> MEM_ADDR=0x00010, MEM_WE=0 at t+1; DISP_VALID=1, DISP_DATA=0xF81F at t+3 only.
2. DISP_REQ held 8 cycles on addresses 0..7 (memory[i]=i+0x100) -> DISP_VALID high 8 consecutive cycles starting t+3, data 0x100..0x107 in order.
3. WR_REQ held with 5 distinct writes (addresses 0x20..0x24, data 0xAAA0..0xAAA4) while DISP_REQ=1 continuously -> 4 acks, WR_LEVEL=4, fifth WR_ACK=0, MEM_WE never 1. Drop DISP_REQ -> writes issued 0x20..0x24 in order, fifth accepted once level<4, WR_LEVEL returns to 0.
4. Interleave DISP_REQ on odd cycles with 3 queued writes -> MEM_WE=1 only in even-cycle slots, no read lost, read latency still 3.
5. Write 0x1234 to 0x30, drain it, then read 0x30 -> DISP_DATA=0x1234.
6. Assert RST_n=0 with 3 queued writes and 2 reads in flight, release -> WR_LEVEL=0, no DISP_VALID, MEM_WE=0, memory unchanged at the queued addresses.
